// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: RV32I funct3 width/sign codes,
// the access FSM state encoding, and helpers that decode access size and
// legality from funct3.
// Optional feature macro used by the unit: MISALIGNED_SPLIT_EN.
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } lsu_state_e;

  // Access size in bytes (1, 2 or 4); only the low two funct3 bits matter.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  // Stores only have B/H/W forms; loads add the unsigned B/H variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store) begin
      f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
    end
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Combinational lane steering shared by both access phases of the LSU.
// Ports:
//   phase2_i     : 1 = second word of a split access (ACC1), 0 = first word
//   off_i        : byte offset addr[1:0]
//   funct3_i     : width/sign code
//   wdata_i      : store data as supplied by the core
//   rdata_i      : word currently returned by memory
//   first_word_i : word captured from the first phase of a split load
//   be_o         : byte enables for the current phase
//   wdata_o      : lane-aligned write data for the current phase
//   ldata_o      : merged, shifted and sign/zero-extended load result
// -----------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        phase2_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] first_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  mask_w;
  logic [63:0] wdata_w;
  logic [5:0]  sh;
  logic [31:0] raw;

  // A two-word view: the low half feeds the first access, the high half the
  // second, so a byte that spills past lane 3 lands in lane 0 of word W+1.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path
    // leaves it unassigned and a latch is never inferred.
    mask_w  = 8'h00;
    case (size_of(funct3_i))
      3'd1:    mask_w = 8'h01;
      3'd2:    mask_w = 8'h03;
      default: mask_w = 8'h0F;
    endcase
    mask_w  = mask_w << off_i;
    wdata_w = {32'h0, wdata_i} << {off_i, 3'b000};
    be_o    = phase2_i ? mask_w[7:4]    : mask_w[3:0];
    wdata_o = phase2_i ? wdata_w[63:32] : wdata_w[31:0];

    // Loads: the first word supplies bytes from off upward; the second word
    // supplies the remaining high bytes (shift by 32 yields zero when off=0).
    sh  = {1'b0, off_i, 3'b000};
    raw = phase2_i ? ((first_word_i >> sh) | (rdata_i << (6'd32 - sh)))
                   : (rdata_i >> sh);

    ldata_o = raw;
    case (funct3_i)
      F3_B:    ldata_o = {{24{raw[7]}},  raw[7:0]};
      F3_H:    ldata_o = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   ldata_o = {24'h0, raw[7:0]};
      F3_HU:   ldata_o = {16'h0, raw[15:0]};
      default: ldata_o = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-stage load/store unit between a multi-cycle core and a word-wide data
// memory. One access per start pulse; req/ack handshake to memory; one-cycle
// done pulse with the extended load result in rdata.
// Optional feature: MISALIGNED_SPLIT_EN -- when defined, accesses crossing a
// word boundary are split into two memory transfers; when undefined, any
// misaligned halfword/word takes the error path.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : one-cycle access request from the core
//   is_store, funct3  : access kind and width/sign code
//   addr, wdata       : byte address and store data
//   rdata             : extended load result, held between loads
//   done              : one-cycle completion pulse
//   busy              : access in progress
//   misalign_err      : pulses with done on a rejected access
//   mem_req/mem_we    : memory request (held until ack) and write qualifier
//   mem_be/mem_addr   : byte enables and word address
//   mem_wdata         : lane-aligned write data
//   mem_rdata/mem_ack : read word and transfer-complete from memory
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              misalign_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  lsu_state_e          state_q, state_d;
  logic                is_store_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         first_q;
  logic [31:0]         rdata_q;

  logic                start_err;
  logic                crosses;
  logic                phase2;
  logic [3:0]          be;
  logic [31:0]         wdata_al;
  logic [31:0]         ldata;
  logic [ADDR_W-1:0]   word_addr;

  // Address bits above the memory window are dropped: word addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

`ifdef MISALIGNED_SPLIT_EN
  assign start_err = !f3_legal(is_store, funct3);
  assign crosses   = ({1'b0, addr_q[1:0]} + size_of(funct3_q)) > 3'd4;
`else
  assign start_err = !f3_legal(is_store, funct3) ||
                     ((size_of(funct3) == 3'd2) && addr[0]) ||
                     ((size_of(funct3) == 3'd4) && (addr[1:0] != 2'b00));
  assign crosses   = 1'b0;
`endif

  assign phase2    = (state_q == ACC1);
  assign word_addr = addr_q[ADDR_W+1:2] + ADDR_W'(phase2);

  lsu_lane_align u_align (
    .phase2_i     (phase2),
    .off_i        (addr_q[1:0]),
    .funct3_i     (funct3_q),
    .wdata_i      (wdata_q),
    .rdata_i      (mem_rdata),
    .first_word_i (first_q),
    .be_o         (be),
    .wdata_o      (wdata_al),
    .ldata_o      (ldata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = start_err ? ERR : ACC0;
      ACC0:    if (mem_ack) state_d = crosses ? ACC1 : RESP;
      ACC1:    if (mem_ack) state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the state register, so reset removes mem_req at once.
  always_comb begin
    mem_req      = (state_q == ACC0) || (state_q == ACC1);
    mem_we       = mem_req && is_store_q;
    mem_be       = mem_req ? be        : 4'h0;
    mem_addr     = mem_req ? word_addr : '0;
    mem_wdata    = mem_req ? wdata_al  : 32'h0;
    done         = (state_q == RESP) || (state_q == ERR);
    misalign_err = (state_q == ERR);
    busy         = (state_q != IDLE);
  end

  assign rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset along with the FSM because
      // rdata must read 0 after reset; they are plain flops, not a RAM.
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      first_q    <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        is_store_q <= is_store;
        funct3_q   <= funct3;
        addr_q     <= addr[ADDR_W+1:0];
        wdata_q    <= wdata;
      end
      if ((state_q == ACC0) && mem_ack && crosses) begin
        first_q <= mem_rdata;
      end
      if (mem_ack && !is_store_q &&
          (((state_q == ACC0) && !crosses) || (state_q == ACC1))) begin
        rdata_q <= ldata;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: a byte-addressed reference model of the data memory
// predicts every memory transfer and load result from the access rules.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam int ADDR_W = 10;
`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              is_store;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              busy;
  logic              misalign_err;
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [1024];
  logic [31:0] exp_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_store     (is_store),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .done         (done),
    .busy         (busy),
    .misalign_err (misalign_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // One complete access: the model lists the byte addresses touched, groups
  // them into words, and answers each memory request after `delay` idle cycles.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int delay, input bit repulse);
    int          sz;
    int          n;
    bit          legal;
    bit          err;
    logic [9:0]  w_addr [2];
    logic [3:0]  w_be   [2];
    logic [31:0] w_wd   [2];
    logic [31:0] ldv;
    logic [31:0] exp_ld;
    logic [11:0] b;

    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = st ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    err   = !legal || (!SPLIT && ((int'(a[1:0]) % sz) != 0));

    n   = 0;
    ldv = 32'h0;
    for (int k = 0; k < 2; k++) begin
      w_addr[k] = '0; w_be[k] = '0; w_wd[k] = '0;
    end
    for (int i = 0; i < sz; i++) begin
      b = a[11:0] + 12'(i);
      if (n == 0 || b[11:2] != w_addr[n-1]) begin
        w_addr[n] = b[11:2];
        n++;
      end
      w_be[n-1][b[1:0]]         = 1'b1;
      w_wd[n-1][8*b[1:0] +: 8]  = wd[8*i +: 8];
      ldv[8*i +: 8]             = mem[b[11:2]][8*b[1:0] +: 8];
    end
    case (f3)
      3'b000:  exp_ld = {{24{ldv[7]}}, ldv[7:0]};
      3'b001:  exp_ld = {{16{ldv[15]}}, ldv[15:0]};
      3'b100:  exp_ld = {24'h0, ldv[7:0]};
      3'b101:  exp_ld = {16'h0, ldv[15:0]};
      default: exp_ld = ldv;
    endcase

    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;

    if (err) begin
      check("err_done",  32'(done), 32'(1'b1));
      check("err_flag",  32'(misalign_err), 32'(1'b1));
      check("err_noreq", 32'(mem_req), 32'(1'b0));
      check("err_rdata", rdata, exp_rdata);
      @(negedge clk);
      check("err_done_clr", 32'(done), 32'(1'b0));
      check("err_flag_clr", 32'(misalign_err), 32'(1'b0));
      check("err_idle",     32'(busy), 32'(1'b0));
    end else begin
      for (int k = 0; k < n; k++) begin
        for (int d = 0; d <= delay; d++) begin
          if (d == delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[w_addr[k]];
          end else if (repulse && k == 0 && d == 0) begin
            start = 1'b1; is_store = !st; funct3 = 3'b011; addr = ~a; wdata = ~wd;
          end
          check("req",   32'(mem_req), 32'(1'b1));
          check("we",    32'(mem_we), 32'(st));
          check("be",    32'(mem_be), 32'(w_be[k]));
          check("maddr", 32'(mem_addr), 32'(w_addr[k]));
          check("wdata", mem_wdata & lane_mask(w_be[k]), w_wd[k]);
          check("early_done", 32'(done), 32'(1'b0));
          @(negedge clk);
          start = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom();
        end
      end
      if (st) begin
        for (int k = 0; k < n; k++)
          for (int l = 0; l < 4; l++)
            if (w_be[k][l]) mem[w_addr[k]][8*l +: 8] = w_wd[k][8*l +: 8];
      end else begin
        exp_rdata = exp_ld;
      end
      check("resp_done",  32'(done), 32'(1'b1));
      check("resp_noerr", 32'(misalign_err), 32'(1'b0));
      check("resp_noreq", 32'(mem_req), 32'(1'b0));
      check("resp_rdata", rdata, exp_rdata);
      @(negedge clk);
      check("done_clr", 32'(done), 32'(1'b0));
      check("idle",     32'(busy), 32'(1'b0));
    end
  endtask

  initial begin
    logic [9:0]  w;
    logic [31:0] a;

    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    exp_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom();

    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_done",  32'(done), 32'(1'b0));
    check("rst_busy",  32'(busy), 32'(1'b0));
    check("rst_err",   32'(misalign_err), 32'(1'b0));
    check("rst_req",   32'(mem_req), 32'(1'b0));
    check("rst_we",    32'(mem_we), 32'(1'b0));
    check("rst_be",    32'(mem_be), 32'h0);
    check("rst_addr",  32'(mem_addr), 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // SW aligned, memory answers on the second request cycle.
    run_access(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 1, 1'b0);

    // LB / LBU of the top byte of word 0x40.
    mem[10'h040] = 32'h80AA_BBCC;
    run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 1'b0);
    check("lb_sign", rdata, 32'hFFFF_FF80);
    run_access(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 1'b0);
    check("lbu_zero", rdata, 32'h0000_0080);

    // SH into the upper half of word 0x40.
    run_access(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 0, 1'b0);

    // LW straddling words 0x40/0x41.
    mem[10'h040] = 32'h4433_2211;
    mem[10'h041] = 32'h8877_6655;
    run_access(1'b0, 3'b010, 32'h0000_0102, 32'h0, 1, 1'b0);
`ifdef MISALIGNED_SPLIT_EN
    check("lw_split", rdata, 32'h6655_4433);
`else
    check("lw_rejected_rdata", rdata, 32'h0000_0080);
`endif

    // Reset while waiting for ack: request drops immediately, no done.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0200;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", 32'(mem_req), 32'(1'b1));
    #1 rst = 1'b1;
    #1;
    check("rst_req_drop", 32'(mem_req), 32'(1'b0));
    check("rst_busy_drop", 32'(busy), 32'(1'b0));
    check("rst_no_done", 32'(done), 32'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 32'h0;
    check("rst_rdata_clr", rdata, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 32'(1'b0));
    end
    run_access(1'b0, 3'b010, 32'h0000_0200, 32'h0, 1, 1'b0);

    // start re-pulsed while busy; then an illegal load code.
    run_access(1'b0, 3'b010, 32'h0000_0204, 32'h0, 2, 1'b1);
    run_access(1'b0, 3'b011, 32'h0000_0300, 32'h0, 0, 1'b0);
    run_access(1'b1, 3'b100, 32'h0000_0300, 32'h1111_2222, 0, 1'b0);

    // Top of the address space with junk in the ignored upper bits.
    run_access(1'b0, 3'b000, 32'hABCD_EFFF, 32'h0, 0, 1'b0);
    run_access(1'b0, 3'b010, 32'h1234_5FFE, 32'h0, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15))
                                      : 10'($urandom_range(1020, 1023));
      a = ($urandom() & 32'hFFFF_F000) | {20'h0, w, 2'($urandom_range(0, 3))};
      run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
